// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory arbiter of the 5-stage core:
// response-owner encoding and default bus widths.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Who owns the memory read data returning in the next cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RD_IF = 2'b01,
    RD_D  = 2'b10,
    WR_D  = 2'b11
  } rsp_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data has fixed priority; a saturating starvation counter forces one fetch
// grant after STARVE_MAX consecutive lost fetch arbitrations. Read data is
// routed back to its owner one cycle after the grant, and a redirect
// (if_flush) kills both new fetch requests and a fetch response in flight.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  input  logic                if_flush,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;
  rsp_owner_t       rsp_owner_r;
  rsp_owner_t       rsp_owner_nxt_s;
  logic             drop_r;
  logic             drop_nxt_s;
  logic             force_if_s;
  logic             if_cand_s;
  logic             d_win_s;
  logic             if_win_s;

  // Pick at most one winner; nothing is granted while reset is asserted.
  always_comb begin
    force_if_s = (starve_cnt_r == CNT_MAX);
    if_cand_s  = if_req_valid && !if_flush;
    d_win_s    = 1'b0;
    if_win_s   = 1'b0;
    if (!rst_n) begin
      d_win_s  = 1'b0;
      if_win_s = 1'b0;
    end else if (d_req_valid && !(force_if_s && if_cand_s)) begin
      d_win_s = 1'b1;
    end else if (if_cand_s) begin
      if_win_s = 1'b1;
    end else begin
      d_win_s  = 1'b0;
      if_win_s = 1'b0;
    end
  end

  // Handshakes and memory command muxed from the winning port.
  always_comb begin
    d_req_ready  = d_win_s;
    if_req_ready = if_win_s;
    mem_en       = 1'b0;
    mem_we       = {STRB_W{1'b0}};
    mem_addr     = {ADDR_W{1'b0}};
    mem_wdata    = {DATA_W{1'b0}};
    if (d_win_s) begin
      mem_en    = 1'b1;
      mem_addr  = d_req_addr;
      mem_wdata = d_req_wdata;
      if (d_req_we) begin
        mem_we = d_req_wstrb;
      end else begin
        mem_we = {STRB_W{1'b0}};
      end
    end else if (if_win_s) begin
      mem_en   = 1'b1;
      mem_addr = if_req_addr;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Next owner, starvation count and drop flag derived from this cycle's grant.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    rsp_owner_nxt_s  = IDLE;
    drop_nxt_s       = if_win_s && if_flush;

    if (!if_req_valid || if_flush || if_win_s) begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (d_win_s && (starve_cnt_r != CNT_MAX)) begin
      starve_cnt_nxt_s = starve_cnt_r + CNT_ONE;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end

    if (d_win_s) begin
      if (d_req_we) begin
        rsp_owner_nxt_s = WR_D;
      end else begin
        rsp_owner_nxt_s = RD_D;
      end
    end else if (if_win_s) begin
      rsp_owner_nxt_s = RD_IF;
    end else begin
      rsp_owner_nxt_s = IDLE;
    end
  end

  // Arbitration state; an asynchronous reset also cancels any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {CNT_W{1'b0}};
      rsp_owner_r  <= IDLE;
      drop_r       <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
      rsp_owner_r  <= rsp_owner_nxt_s;
      drop_r       <= drop_nxt_s;
    end
  end

  // Route the returning read data (or write acknowledge) to its owner.
  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = {DATA_W{1'b0}};
    d_rsp_valid  = 1'b0;
    d_rsp_data   = {DATA_W{1'b0}};
    case (rsp_owner_r)
      RD_D: begin
        d_rsp_valid = 1'b1;
        d_rsp_data  = mem_rdata;
      end
      WR_D: begin
        d_rsp_valid = 1'b1;
        d_rsp_data  = {DATA_W{1'b0}};
      end
      RD_IF: begin
        // A redirect in the response cycle discards the stale instruction.
        if (!drop_r && !if_flush) begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = mem_rdata;
        end else begin
          if_rsp_valid = 1'b0;
          if_rsp_data  = {DATA_W{1'b0}};
        end
      end
      IDLE: begin
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;
      end
      default: begin
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver pushes expected responses,
// an independent monitor pops and compares whenever a response is presented.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid;
  logic        d_req_we;
  logic [3:0]  d_req_wstrb;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] ifq[$];
  logic [31:0] dq[$];
  logic [31:0] bmem [0:255];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model with byte-enable writes.
  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = 32'hC0DE_0000 | 32'(i * 4);
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) bmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= bmem[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples late in each cycle, after the driver has settled inputs.
  initial begin
    forever begin
      @(posedge clk);
      #8;
      if (if_rsp_valid) begin
        if (ifq.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_rsp_unexpected: got data %h expected no response at %0t", if_rsp_data, $time);
        end else begin
          check("if_rsp_data", if_rsp_data, ifq.pop_front());
        end
      end else begin
        check("if_rsp_idle_zero", if_rsp_data, 32'h0);
      end
      if (d_rsp_valid) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_rsp_unexpected: got data %h expected no response at %0t", d_rsp_data, $time);
        end else begin
          check("d_rsp_data", d_rsp_data, dq.pop_front());
        end
      end else begin
        check("d_rsp_idle_zero", d_rsp_data, 32'h0);
      end
    end
  end

  // One cycle of stimulus, grant checks and scoreboard pushes.
  task automatic step(input logic iv, input logic [31:0] ia, input logic fl,
                      input logic dv, input logic we, input logic [3:0] ws,
                      input logic [31:0] da, input logic [31:0] wd,
                      input logic exp_ir, input logic exp_dr,
                      input logic push_if, input logic [31:0] if_exp,
                      input logic push_d, input logic [31:0] d_exp);
    @(posedge clk);
    #6;
    if_req_valid = iv; if_req_addr = ia; if_flush = fl;
    d_req_valid = dv; d_req_we = we; d_req_wstrb = ws; d_req_addr = da; d_req_wdata = wd;
    #1;
    check("if_req_ready", {31'h0, if_req_ready}, {31'h0, exp_ir});
    check("d_req_ready", {31'h0, d_req_ready}, {31'h0, exp_dr});
    check("mem_en", {31'h0, mem_en}, {31'h0, exp_ir | exp_dr});
    if (exp_dr) begin
      check("mem_addr_d", mem_addr, da);
      check("mem_we_d", {28'h0, mem_we}, {28'h0, (we ? ws : 4'h0)});
      if (we) check("mem_wdata", mem_wdata, wd);
    end else if (exp_ir) begin
      check("mem_addr_if", mem_addr, ia);
      check("mem_we_if", {28'h0, mem_we}, 32'h0);
    end
    if (push_if) ifq.push_back(if_exp);
    if (push_d) dq.push_back(d_exp);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Continuous contention; every fifth grant must go to fetch.
  task automatic contend(input int n, input int phase0, input logic [31:0] fa0,
                         input logic [31:0] da0);
    logic [31:0] fa;
    fa = fa0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] da;
      logic        fwin;
      da   = da0 + 32'(4 * k);
      fwin = (((k + phase0) % 5) == 4);
      step(1'b1, fa, 1'b0, 1'b1, 1'b0, 4'h0, da, 32'h0,
           fwin, !fwin, fwin, 32'hC0DE_0000 | fa, !fwin, 32'hC0DE_0000 | da);
      if (fwin) fa = fa + 32'h4;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0; if_flush = 1'b0;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'hF;
    d_req_addr = 32'h0; d_req_wdata = 32'h0;

    // Reset state with both requests asserted.
    @(posedge clk); #7;
    check("rst_if_ready", {31'h0, if_req_ready}, 32'h0);
    check("rst_d_ready", {31'h0, d_req_ready}, 32'h0);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_mem_we", {28'h0, mem_we}, 32'h0);
    check("rst_if_rsp_valid", {31'h0, if_rsp_valid}, 32'h0);
    check("rst_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
    @(posedge clk); #6;
    if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wstrb = 4'h0;
    rst_n = 1'b1;

    // Fetch-only stream.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC0DE_0000, 1'b0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC0DE_0004, 1'b0, 32'h0);
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC0DE_0008, 1'b0, 32'h0);
    idle();

    // Full write, read back, partial write, read back.
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h100, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_5678);
    idle();

    // Contention from a cleared counter: D,D,D,D,F,D,D,D,D,F.
    contend(10, 0, 32'h10, 32'h80);
    idle();

    // Three lost arbitrations, then a flush with both requesting clears the count.
    contend(3, 0, 32'h30, 32'hC0);
    step(1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 4'h0, 32'hCC, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC0DE_00CC);
    contend(5, 0, 32'h30, 32'hD0);
    idle();

    // Flush in the response cycle discards the fetch; refetch next cycle.
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC0DE_0024, 1'b0, 32'h0);
    idle();

    // Reset in the cycle after a data read grant kills its response.
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #6;
    rst_n = 1'b0; if_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    check("midrst_if_ready", {31'h0, if_req_ready}, 32'h0);
    check("midrst_d_ready", {31'h0, d_req_ready}, 32'h0);
    check("midrst_mem_en", {31'h0, mem_en}, 32'h0);
    check("midrst_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
    @(posedge clk); #6;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC0DE_0044);
    idle();
    idle();
    idle();

    check("ifq_drained", 32'(ifq.size()), 32'h0);
    check("dq_drained", 32'(dq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
